// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with 2-credit memory requests, in-order PC FIFO and 2-entry instruction queue.
// Define FETCH_BYPASS_EN to present a response on o_valid in its arrival cycle when the queue is empty.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ready,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_stall,
   output logic        o_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc
);
`ifdef FETCH_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif
   logic [31:0] pc;
   logic [1:0]  outst, q_cnt, drop_cnt;
   logic [31:0] pf [2];
   logic [31:0] q_inst [2];
   logic [31:0] q_pc [2];
   logic        req, accept, resp, keep, bypass_hit, push, pop, pf_widx, q_widx;
   // Outstanding requests include ones whose responses will be dropped, so credits stay exact across redirects.
   always_comb begin
      req         = !i_rst && !i_redirect && (({1'b0, outst} + {1'b0, q_cnt}) < 3'd2);
      accept      = req && i_imem_ready;
      resp        = i_imem_rvalid && (outst != 2'd0);
      keep        = resp && (drop_cnt == 2'd0) && !i_redirect;
      bypass_hit  = BYPASS && keep && (q_cnt == 2'd0);
      pop         = (q_cnt != 2'd0) && !i_stall && !i_redirect;
      push        = keep && !(bypass_hit && !i_stall);
      pf_widx     = outst[0] ^ resp;
      q_widx      = q_cnt[0] ^ pop;
      o_imem_req  = req;
      o_imem_addr = pc;
      o_valid     = !i_rst && !i_redirect && ((q_cnt != 2'd0) || bypass_hit);
      o_inst      = i_rst ? 32'd0 : bypass_hit ? i_imem_rdata : q_inst[0];
      o_pc        = i_rst ? 32'd0 : bypass_hit ? pf[0] : q_pc[0];
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc        <= RESET_PC;
         outst     <= 2'd0;
         q_cnt     <= 2'd0;
         drop_cnt  <= 2'd0;
         pf[0]     <= '0;
         pf[1]     <= '0;
         q_inst[0] <= '0;
         q_inst[1] <= '0;
         q_pc[0]   <= '0;
         q_pc[1]   <= '0;
      end else begin
         pc       <= i_redirect ? (i_redirect_pc & ~32'h3) : accept ? pc + 32'd4 : pc;
         outst    <= outst + {1'b0, accept} - {1'b0, resp};
         drop_cnt <= i_redirect ? outst - {1'b0, resp} : drop_cnt - {1'b0, resp && (drop_cnt != 2'd0)};
         if (resp) pf[0] <= pf[1];
         if (accept) pf[pf_widx] <= pc;
         q_cnt    <= i_redirect ? 2'd0 : q_cnt + {1'b0, push} - {1'b0, pop};
         if (pop) begin
            q_inst[0] <= q_inst[1];
            q_pc[0]   <= q_pc[1];
         end
         if (push) begin
            q_inst[q_widx] <= i_imem_rdata;
            q_pc[q_widx]   <= pf[0];
         end
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed corner sequences, a redirect alignment table and randomized traffic
// checked against a queue-based model of the fetch rules; honours FETCH_BYPASS_EN.
module tb_fetch_stage;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   logic clk = 0, rst = 1, rdy = 0, rvalid = 0, redirect = 0, stall = 0;
   logic req, valid;
   logic [31:0] addr, inst, pc, rdata = 0, rpc = 0;
   always #5 clk = ~clk;
   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .i_clk(clk), .i_rst(rst), .o_imem_req(req), .o_imem_addr(addr), .i_imem_ready(rdy),
      .i_imem_rvalid(rvalid), .i_imem_rdata(rdata), .i_redirect(redirect), .i_redirect_pc(rpc),
      .i_stall(stall), .o_valid(valid), .o_inst(inst), .o_pc(pc));
   typedef struct {logic [31:0] addr; int epoch; int due;} fl_t;
   typedef struct {logic [31:0] rpc; logic [31:0] exp_addr;} vec_t;
   fl_t inflight[$];
   logic [31:0] expq[$], acc_log[$], cons_log[$];
   logic [31:0] mpc = RST_PC;
   int epoch = 0, cyc = 0, checks = 0, failures = 0, lat_min = 1, lat_max = 1;
   bit force_rv = 0;
   logic s_req, s_valid, s_rv;
   logic [31:0] s_addr, s_pc, s_inst;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   task automatic do_reset();
      rst = 1; rvalid = 0; redirect = 0; force_rv = 0;
      inflight.delete(); expq.delete(); mpc = RST_PC;
      #1;
      chk("rst_req", req, 0); chk("rst_valid", valid, 0);
      chk("rst_inst", inst, 0); chk("rst_pc", pc, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      acc_log.delete(); cons_log.delete();
   endtask
   // One clock: memory drives its in-order head, outputs are compared at negedge, then the model advances.
   task automatic step();
      logic rv, kept, byp_now, e_req, e_valid, direct;
      logic [31:0] hp;
      fl_t f;
      if (inflight.size() > 0 && inflight[0].due <= cyc) begin
         rvalid = 1; rdata = ~inflight[0].addr;
      end else begin
         rvalid = force_rv; rdata = $urandom;
      end
      @(negedge clk);
      s_req = req; s_valid = valid; s_addr = addr; s_pc = pc; s_inst = inst; s_rv = rvalid;
      rv      = rvalid && inflight.size() > 0;
      kept    = rv && !redirect && inflight[0].epoch == epoch;
      hp      = expq.size() > 0 ? expq[0] : inflight.size() > 0 ? inflight[0].addr : '0;
      byp_now = BYP && kept && expq.size() == 0;
      e_req   = !redirect && (inflight.size() + expq.size() < 2);
      e_valid = !redirect && (expq.size() > 0 || byp_now);
      chk("m_req", req, e_req);
      chk("m_addr", addr, mpc);
      chk("m_valid", valid, e_valid);
      if (e_valid) begin
         chk("m_pc", pc, hp);
         chk("m_inst", inst, ~hp);
      end
      if (req && rdy) acc_log.push_back(addr);
      if (valid && !stall) cons_log.push_back(pc);
      if (redirect) begin
         if (rv) void'(inflight.pop_front());
         epoch++;
         expq.delete();
         mpc = {rpc[31:2], 2'b00};
      end else begin
         direct = e_valid && !stall && expq.size() == 0;
         if (e_valid && !stall && expq.size() > 0) void'(expq.pop_front());
         if (rv) begin
            f = inflight.pop_front();
            if (kept && !direct) expq.push_back(f.addr);
         end
         if (e_req && rdy) begin
            inflight.push_back('{mpc, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
            mpc += 32'd4;
         end
      end
      @(posedge clk); #1;
      cyc++;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end
   initial begin
      vec_t tbl[4];
      logic [31:0] first;
      tbl[0] = '{32'h0000_0103, 32'h0000_0100};
      tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
      tbl[2] = '{32'h1234_5678, 32'h1234_5678};
      tbl[3] = '{32'h8000_0002, 32'h8000_0000};
      do_reset();
      // in-order stream 0,4,8 with single-cycle latency
      rdy = 1; stall = 0; lat_min = 1; lat_max = 1;
      repeat (10) step();
      chk("seq_cons_n", cons_log.size() >= 3, 1);
      for (int i = 0; i < 3; i++) begin
         chk("seq_acc", acc_log[i], 32'(i * 4));
         chk("seq_cons", cons_log[i], 32'(i * 4));
      end
      // bypass vs enqueue timing with empty queue
      do_reset();
      step(); step();
      chk("byp_rv", s_rv, 1);
      chk("byp_valid", s_valid, BYP);
      step();
      chk("byp_next_valid", s_valid, 1);
      chk("byp_next_pc", s_pc, BYP ? 32'd4 : 32'd0);
      // stalled decode: two requests then credit exhausted
      do_reset();
      stall = 1;
      repeat (10) step();
      chk("stall_acc_n", acc_log.size(), 2);
      chk("stall_req", s_req, 0);
      chk("stall_valid", s_valid, 1);
      chk("stall_pc", s_pc, 0);
      stall = 0; acc_log.delete();
      for (int i = 0; i < 10 && acc_log.size() == 0; i++) step();
      first = acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF;
      chk("stall_resume", first, 32'h8);
      // redirect with two responses in flight
      do_reset();
      lat_min = 4; lat_max = 4;
      step(); step();
      chk("rd_acc_n", acc_log.size(), 2);
      redirect = 1; rpc = 32'h0000_0103;
      step();
      chk("rd_req", s_req, 0);
      chk("rd_valid", s_valid, 0);
      redirect = 0;
      step();
      chk("rd_addr", s_addr, 32'h100);
      acc_log.delete(); cons_log.delete();
      for (int i = 0; i < 30 && cons_log.size() == 0; i++) step();
      first = cons_log.size() > 0 ? cons_log[0] : 32'hDEAD_BEEF;
      chk("rd_first_pc", first, 32'h100);
      first = acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF;
      chk("rd_first_acc", first, 32'h100);
      lat_min = 1; lat_max = 1;
      // memory not ready: address held, then spurious rvalid ignored
      do_reset();
      rdy = 0;
      repeat (3) begin
         step();
         chk("nrdy_req", s_req, 1);
         chk("nrdy_addr", s_addr, RST_PC);
      end
      chk("nrdy_acc_n", acc_log.size(), 0);
      force_rv = 1; step(); force_rv = 0;
      step();
      chk("spurious_valid", s_valid, 0);
      rdy = 1; step(); step();
      chk("rdy_advance", s_addr, 32'h4);
      // redirect alignment table
      rdy = 0;
      repeat (4) step();
      for (int i = 0; i < 4; i++) begin
         redirect = 1; rpc = tbl[i].rpc;
         step();
         chk("tbl_req_rd", s_req, 0);
         chk("tbl_valid_rd", s_valid, 0);
         redirect = 0;
         step();
         chk("tbl_addr", s_addr, tbl[i].exp_addr);
         chk("tbl_req", s_req, 1);
      end
      // randomized traffic against the model
      lat_min = 1; lat_max = 3;
      repeat (400) begin
         rdy = $urandom_range(3, 0) != 0;
         stall = $urandom_range(2, 0) == 0;
         redirect = $urandom_range(11, 0) == 0;
         rpc = $urandom;
         step();
      end
      redirect = 0;
      // reset asserted mid-burst
      rdy = 1; stall = 0;
      repeat (5) step();
      #2;
      do_reset();
      step();
      chk("post_rst_req", s_req, 1);
      chk("post_rst_addr", s_addr, RST_PC);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
